// File: rtl/call_return_stack.sv
// call_return_stack: hardware return-address stack feeding program_counter's parallel load.
//   A call pushes pc_in+1 and loads the PC with target. A ret pops the saved address
//   and loads the PC with it. Each accepted request produces a one-cycle LOAD phase.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   call, ret           - decoder requests, sampled on the rising edge
//   pc_in, target       - current PC value and call destination
//   pc_ld, pc_ld_addr   - load strobe and address to program_counter
//   busy                - load in flight; requests now are protocol errors
//   depth, full, empty  - stack occupancy
//   overflow, underflow, proto_err - sticky error flags, cleared only by reset
module call_return_stack #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          call,
    input  logic          ret,
    input  logic [AW-1:0] pc_in,
    input  logic [AW-1:0] target,
    output logic          pc_ld,
    output logic [AW-1:0] pc_ld_addr,
    output logic          busy,
    output logic [CW-1:0] depth,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow,
    output logic          proto_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Reject unsupported depths at elaboration.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("call_return_stack: DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          pc_ld_q, pc_ld_d;
    logic [AW-1:0] pc_ld_addr_q, pc_ld_addr_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] depth_q, depth_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          proto_err_q, proto_err_d;

    logic [AW-1:0] mem_q [DEPTH];
    logic          push_en;
    logic [PW-1:0] push_idx;
    logic [PW-1:0] pop_idx;
    logic [AW-1:0] ret_addr;

    // Stack pointer arithmetic: push writes at depth, pop reads depth-1.
    assign push_idx = depth_q[PW-1:0];
    assign pop_idx  = PW'(depth_q - CW'(1));
    assign ret_addr = pc_in + AW'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d      = ST_IDLE;
        pc_ld_d      = 1'b0;
        busy_d       = 1'b0;
        pc_ld_addr_d = pc_ld_addr_q;
        depth_d      = depth_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        proto_err_d  = proto_err_q;
        push_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (call && ret) begin
                    proto_err_d = 1'b1;
                end else if (call) begin
                    if (full_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        push_en      = 1'b1;
                        depth_d      = depth_q + CW'(1);
                        pc_ld_addr_d = target;
                        pc_ld_d      = 1'b1;
                        busy_d       = 1'b1;
                        state_d      = ST_LOAD;
                    end
                end else if (ret) begin
                    if (empty_q) begin
                        underflow_d = 1'b1;
                    end else begin
                        depth_d      = depth_q - CW'(1);
                        pc_ld_addr_d = mem_q[pop_idx];
                        pc_ld_d      = 1'b1;
                        busy_d       = 1'b1;
                        state_d      = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                // pc_in is stale during the load, so any request here is illegal.
                if (call || ret) begin
                    proto_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        full_d  = (depth_d == CW'(DEPTH));
        empty_d = (depth_d == CW'(0));
    end

    // State and output registers; reset wins over any same-cycle request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_ld_q      <= 1'b0;
            pc_ld_addr_q <= '0;
            busy_q       <= 1'b0;
            depth_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_ld_q      <= pc_ld_d;
            pc_ld_addr_q <= pc_ld_addr_d;
            busy_q       <= busy_d;
            depth_q      <= depth_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Stack storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (!reset && push_en) begin
            mem_q[push_idx] <= ret_addr;
        end
    end

    assign pc_ld      = pc_ld_q;
    assign pc_ld_addr = pc_ld_addr_q;
    assign busy       = busy_q;
    assign depth      = depth_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign proto_err  = proto_err_q;

endmodule

// File: doc/call_return_stack.md
Name: call_return_stack

Overview:
- Hardware return-address stack that drives the program counter's parallel-load port.
- On a CALL request it pushes the return address (current PC + 1) and loads the PC with the call target.
- On a RET request it pops the saved return address and loads the PC with it.
- Sits between the instruction decoder (which issues call/ret) and program_counter (ld/inp inputs).

Parameters:
- AW, 8, address width; matches the PC width.
- DEPTH, 8, number of stack entries; must be a power of 2 and at least 2.
- CW, $clog2(DEPTH+1), width of the depth count output (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- call  input  1  request a subroutine call; sampled on the rising edge.
- ret  input  1  request a return; sampled on the rising edge.
- pc_in  input  AW  current PC value (program_counter out).
- target  input  AW  call destination address; valid with call.
- pc_ld  output  1  load strobe to program_counter ld; a one-cycle pulse.
- pc_ld_addr  output  AW  address to program_counter inp; valid while pc_ld=1.
- busy  output  1  high while a PC load is in flight; the decoder must not issue requests.
- depth  output  CW  number of valid entries (0..DEPTH).
- full  output  1  depth == DEPTH.
- empty  output  1  depth == 0.
- overflow  output  1  sticky: a call was attempted while full.
- underflow  output  1  sticky: a ret was attempted while empty.
- proto_err  output  1  sticky: illegal request (call and ret together, or any request while busy).

Behaviour:
- Reset (synchronous, highest priority, overrides any request in the same cycle):
  - pc_ld=0, pc_ld_addr=0, busy=0, depth=0, empty=1, full=0.
  - overflow, underflow and proto_err cleared.
  - FSM returns to IDLE. Stack RAM contents are don't-care.
  - Reset mid-operation abandons any in-flight load: pc_ld is 0 in the cycle after reset is sampled.
- FSM has two states, IDLE and LOAD. All outputs are registered.
- IDLE, call=1, ret=0, not full:
  - mem[depth] <= pc_in + 1, computed mod 2^AW (0xFF+1 wraps to 0x00).
  - depth increments; pc_ld_addr <= target; pc_ld <= 1; go to LOAD.
- IDLE, ret=1, call=0, not empty:
  - pc_ld_addr <= mem[depth-1]; depth decrements; pc_ld <= 1; go to LOAD.
- IDLE, call while full: no push, no load, overflow <= 1, stay in IDLE.
- IDLE, ret while empty: no pop, no load, underflow <= 1, stay in IDLE.
- IDLE, call=1 and ret=1 together: no stack change, no load, proto_err <= 1.
- LOAD:
  - pc_ld=1 and busy=1 for exactly this one cycle; program_counter loads on the edge that ends it.
  - Unconditional return to IDLE; pc_ld <= 0.
  - Any call/ret sampled in LOAD is ignored and sets proto_err, because pc_in is stale in this cycle.
- Latency: request sampled at edge N -> pc_ld high during cycle N..N+1 -> PC holds the new value after edge N+1.
  - Next legal request: at edge N+2, so the maximum sustained rate is one request per 2 cycles.
- pc_ld_addr holds its last value while pc_ld=0.
- Sticky flags are cleared only by reset.
- full, empty and depth are derived from the registered depth counter and change only on an accepted push/pop or on reset.
- No bypass or forwarding: a pop always returns the value written by an earlier accepted push.

Test Plan:
- Reset with call=1 held -> depth=0, empty=1, pc_ld=0, all sticky flags 0; no push occurs.
- pc_in=0x05, target=0x40, call pulse -> next cycle pc_ld=1, pc_ld_addr=0x40, depth=1. Then pc_in=0x40, ret pulse -> pc_ld=1, pc_ld_addr=0x06, depth=0, empty=1.
- Nested calls from pc_in=0x10, 0x20, 0x30, then three rets -> pc_ld_addr sequence 0x31, 0x21, 0x11 (LIFO order); busy high for exactly one cycle per request.
- pc_in=0xFF, call -> saved return address 0x00 (wrap); a later ret yields pc_ld_addr=0x00.
- DEPTH=8: 8 accepted calls -> full=1. A 9th call -> overflow=1, pc_ld stays 0, depth stays 8. Ret on empty -> underflow=1, no pc_ld. call and ret together -> proto_err=1, depth unchanged.
- A call issued in the LOAD cycle -> ignored, proto_err=1. A reset asserted during LOAD -> pc_ld=0 next cycle, depth=0.
